// File: rtl/mips_mc_pkg.sv
// Shared encodings, FSM states, ALU operations and the immediate sign-extend helper
// for the multi-cycle MIPS core.
package mips_mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        RST_WAIT,
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        TRAP
    } state_e;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_e;

    // Widest legal datapath is 64 bits; callers keep the low XLEN bits.
    function automatic logic [63:0] sext16(input logic [15:0] v);
        return {{48{v[15]}}, v};
    endfunction

endpackage

// File: rtl/mips_mc_regfile.sv
// 32 x XLEN register file: two asynchronous read ports, one synchronous write port,
// r0 hardwired to zero, asynchronous active-low clear.
module mips_mc_regfile
    import mips_mc_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4:0]      ra1,
    input  logic [4:0]      ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            we,
    input  logic [4:0]      wa,
    input  logic [XLEN-1:0] wd
);

    logic [XLEN-1:0] regs_q [32];
    logic [XLEN-1:0] regs_d [32];

    always_comb begin
        regs_d = regs_q;
        if (we && (wa != 5'd0)) begin
            regs_d[wa] = wd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rd1 = (ra1 == 5'd0) ? '0 : regs_q[ra1];
    assign rd2 = (ra2 == 5'd0) ? '0 : regs_q[ra2];

endmodule

// File: rtl/mips_mc_core.sv
// Multi-cycle MIPS core sharing one request/ready memory port for fetch and data.
// Define MIPS_MC_TRAP_EN to trap on unsupported instructions instead of treating them as NOPs.
module mips_mc_core
    import mips_mc_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ready,
    output logic [XLEN-1:0] pc,
    output logic            retire,
    output logic            trap
);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     ir_q, ir_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] alu_q, alu_d;
    logic [XLEN-1:0] mdr_q, mdr_d;

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm16;
    logic [25:0] imm26;

    assign opcode = ir_q[31:26];
    assign rs     = ir_q[25:21];
    assign rt     = ir_q[20:16];
    assign rd     = ir_q[15:11];
    assign funct  = ir_q[5:0];
    assign imm16  = ir_q[15:0];
    assign imm26  = ir_q[25:0];

    logic [63:0]     imm_sx;
    logic [XLEN-1:0] imm_ext;
    assign imm_sx  = sext16(imm16);
    assign imm_ext = imm_sx[XLEN-1:0];

    logic [XLEN-1:0] rs_val, rt_val;
    logic            rf_we;
    logic [4:0]      rf_wa;
    logic [XLEN-1:0] rf_wd;

    mips_mc_regfile #(.XLEN(XLEN)) u_rf (
        .clk   (clk),
        .rst_n (rst),
        .ra1   (rs),
        .ra2   (rt),
        .rd1   (rs_val),
        .rd2   (rt_val),
        .we    (rf_we),
        .wa    (rf_wa),
        .wd    (rf_wd)
    );

    // Decode: legality and ALU operation selection.
    logic    is_rtype, legal;
    alu_op_e alu_op;

    always_comb begin
        is_rtype = (opcode == OP_RTYPE);
        legal    = 1'b0;
        alu_op   = ALU_ADD;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  begin legal = 1'b1; alu_op = ALU_ADD; end
                    FN_SUB:  begin legal = 1'b1; alu_op = ALU_SUB; end
                    FN_AND:  begin legal = 1'b1; alu_op = ALU_AND; end
                    FN_OR:   begin legal = 1'b1; alu_op = ALU_OR;  end
                    FN_SLT:  begin legal = 1'b1; alu_op = ALU_SLT; end
                    default: legal = 1'b0;
                endcase
            end
            OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    // ALU: second operand is B for R-type, the sign-extended immediate otherwise.
    logic [XLEN-1:0] alu_b, alu_res;

    always_comb begin
        alu_b = is_rtype ? b_q : imm_ext;
        case (alu_op)
            ALU_ADD: alu_res = a_q + alu_b;
            ALU_SUB: alu_res = a_q - alu_b;
            ALU_AND: alu_res = a_q & alu_b;
            ALU_OR:  alu_res = a_q | alu_b;
            ALU_SLT: alu_res = {{(XLEN-1){1'b0}}, ($signed(a_q) < $signed(alu_b))};
            default: alu_res = a_q + alu_b;
        endcase
    end

`ifdef MIPS_MC_TRAP_EN
    logic trap_q, trap_d;
`endif

    logic [XLEN-1:0] mem_addr_raw;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        a_d          = a_q;
        b_d          = b_q;
        alu_d        = alu_q;
        mdr_d        = mdr_q;
        rf_we        = 1'b0;
        rf_wa        = rt;
        rf_wd        = alu_q;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_raw = pc_q;
        retire       = 1'b0;
`ifdef MIPS_MC_TRAP_EN
        trap_d       = trap_q;
`endif
        case (state_q)
            RST_WAIT: state_d = FETCH;
            FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_d    = mem_rdata[31:0];
                    pc_d    = pc_q + XLEN'(4);
                    state_d = DECODE;
                end
            end
            DECODE: begin
                a_d   = rs_val;
                b_d   = rt_val;
                alu_d = pc_q + (imm_ext << 2);
                if (!legal) begin
`ifdef MIPS_MC_TRAP_EN
                    trap_d  = 1'b1;
                    state_d = TRAP;
`else
                    retire  = 1'b1;
                    state_d = FETCH;
`endif
                end else if (opcode == OP_J) begin
                    pc_d    = {pc_q[XLEN-1:28], imm26, 2'b00};
                    retire  = 1'b1;
                    state_d = FETCH;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                case (opcode)
                    OP_RTYPE, OP_ADDI: begin
                        alu_d   = alu_res;
                        state_d = WB;
                    end
                    OP_LW, OP_SW: begin
                        alu_d   = alu_res;
                        state_d = MEM;
                    end
                    OP_BEQ: begin
                        // alu_q still holds the branch target computed in DECODE.
                        if (a_q == b_q) begin
                            pc_d = alu_q;
                        end
                        retire  = 1'b1;
                        state_d = FETCH;
                    end
                    default: state_d = FETCH;
                endcase
            end
            MEM: begin
                mem_req      = 1'b1;
                mem_we       = (opcode == OP_SW);
                mem_addr_raw = alu_q;
                if (mem_ready) begin
                    if (opcode == OP_SW) begin
                        retire  = 1'b1;
                        state_d = FETCH;
                    end else begin
                        mdr_d   = mem_rdata;
                        state_d = WB;
                    end
                end
            end
            WB: begin
                rf_we   = 1'b1;
                rf_wa   = is_rtype ? rd : rt;
                rf_wd   = (opcode == OP_LW) ? mdr_q : alu_q;
                retire  = 1'b1;
                state_d = FETCH;
            end
            TRAP: state_d = TRAP;
            default: state_d = RST_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RST_WAIT;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            alu_q   <= '0;
            mdr_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            alu_q   <= alu_d;
            mdr_q   <= mdr_d;
        end
    end

`ifdef MIPS_MC_TRAP_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            trap_q <= 1'b0;
        end else begin
            trap_q <= trap_d;
        end
    end
    assign trap = trap_q;
`else
    assign trap = 1'b0;
`endif

    assign mem_addr  = {mem_addr_raw[XLEN-1:2], 2'b00};
    assign mem_wdata = b_q;
    assign pc        = pc_q;

endmodule

// File: doc/mips_mc_core.md
# mips_mc_core

Multi-cycle MIPS core. A finite-state controller sequences each instruction through fetch, decode, execute, memory and write-back. Instructions and data share one memory port with a request/ready handshake, so the core tolerates variable-latency memory. It is the parametrised successor to the single-cycle datapath: configurable datapath width and reset vector, with memory stalls and retire/trap observability.

## Interface
- XLEN, 32: datapath/register/PC width; legal values 32 or 64; instruction word always 32 bits.
- RESET_PC, 0: PC value loaded on reset.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- mem_req  out  1  memory transaction request.
- mem_we  out  1  1 = write (sw), 0 = read (fetch, lw).
- mem_addr  out  XLEN  byte address, word-aligned.
- mem_wdata  out  XLEN  store data.
- mem_rdata  in  XLEN  read data; valid in the cycle mem_ready=1. Instruction is bits [31:0].
- mem_ready  in  1  transaction completes this cycle.
- pc  out  XLEN  current PC.
- retire  out  1  one-cycle pulse in an instruction's final cycle.
- trap  out  1  sticky illegal-instruction flag (see Configuration).

## Operation
- Supported instructions:
  - R-type funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A.
  - addi 0x08, lw 0x23, sw 0x2B, beq 0x04, j 0x02.
- States: RST_WAIT, FETCH, DECODE, EXEC, MEM, WB, TRAP.
- RST_WAIT: entered on reset; advances to FETCH on the first clock edge after rst deasserts.
- FETCH: mem_req=1, mem_we=0, mem_addr=pc. On mem_ready: IR<=mem_rdata[31:0], pc<=pc+4, go to DECODE. Otherwise stay.
- DECODE: A<=rf[rs], B<=rf[rt]. ALUOut<=pc+(sext(imm16)<<2) (branch target). Next state:
  - j: pc<={pc[XLEN-1:28], imm26, 2'b00}, retire, go to FETCH.
  - any other legal instruction: go to EXEC.
- EXEC:
  - R-type/addi: ALUOut<=A op B, or A+sext(imm); go to WB.
  - lw/sw: ALUOut<=A+sext(imm); go to MEM.
  - beq: if A==B, pc<=ALUOut; retire; go to FETCH.
- MEM: mem_req=1, mem_addr=ALUOut, mem_we=(sw), mem_wdata=B. On mem_ready:
  - sw: retire, go to FETCH.
  - lw: MDR<=mem_rdata, go to WB.
- WB: write rd (R-type), or rt (addi/lw), with ALUOut or MDR; retire; go to FETCH.
- Writes to r0 are discarded; r0 always reads 0.
- Arithmetic wraps modulo 2^XLEN; no overflow exception. slt is a signed compare and writes 1 or 0.
- mem_addr[1:0] is forced to 0; the low address bits are ignored.

## Timing
- Reset values (asynchronous):
  - state=RST_WAIT, pc=RESET_PC.
  - IR, A, B, ALUOut, MDR and all registers = 0.
  - mem_req=0, mem_we=0, retire=0, trap=0.
- Latency in cycles, assuming mem_ready is high in the first request cycle:
  - j: 2. beq: 3. R-type/addi/sw: 4. lw: 5.
  - Each wait cycle (mem_ready low) adds 1.
- Handshake:
  - mem_addr, mem_we and mem_wdata stay stable while mem_req=1 and mem_ready=0.
  - mem_req drops the cycle after completion if the next state is not a memory state.
  - mem_ready while mem_req=0 is ignored.
- Back-to-back: FETCH follows retire with no bubble.
- Reset mid-transaction aborts immediately: mem_req goes low asynchronously and no register-file write occurs.

## Configuration
- MIPS_MC_TRAP_EN defined:
  - An unsupported opcode or funct in DECODE sets trap=1 and enters TRAP.
  - In TRAP: no memory requests and no retire; only reset exits.
  - pc holds the address of the faulting instruction +4.
- MIPS_MC_TRAP_EN undefined:
  - An unsupported instruction is a NOP: retire pulses in DECODE, then FETCH.
  - trap is tied to 0.

## Structure
- Package mips_mc_pkg holds:
  - opcode and funct localparams;
  - the state enum;
  - the ALU operation enum (ADD, SUB, AND, OR, SLT);
  - the sign-extend function.
- Sub-module mips_mc_regfile: 32×XLEN, two asynchronous read ports, one synchronous write port, r0 hardwired to zero, asynchronous active-low clear.
- ALU and controller are inline in the core.

## Test plan
- Reset with RESET_PC=0x100, then release rst: first mem_req occurs one cycle after release with mem_addr=0x100; pc=0x100.
- addi r1,r0,5; addi r2,r0,-3; add r3,r1,r2; slt r4,r2,r1 with zero-wait memory: r3=2, r4=1, 4 retire pulses at 4-cycle spacing.
- sw r1,8(r0) then lw r5,8(r0) with mem_ready delayed 2 cycles per transaction:
  - the write carries mem_addr=8 and mem_wdata=5;
  - r5=5;
  - lw takes 5+4=9 cycles;
  - the address is stable throughout the stalls.
- beq r1,r1,-1 at 0x10 (taken): pc=0x10 after 3 cycles. beq r1,r2,+4 (not taken): pc advances by 4.
- j 0x40 from pc 0x20: next fetch address is 0x100; retire pulses 2 cycles after the fetch request.
- Opcode 0x3F:
  - with MIPS_MC_TRAP_EN: trap=1 and no further mem_req;
  - without: retire pulses and the next fetch is at pc+4.
- Extra check: assert rst low during a stalled lw; verify mem_req=0 immediately and the target register is unchanged.
